// File: rtl/trng_sample_ctrl_if.sv
// Handshake bundle between the TRNG sampling controller and its environment:
// control inputs, the raw entropy bit, and the conditioned-word outputs.
interface trng_sample_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic             start;
  logic [DIV_W-1:0] cfg_div;
  logic             raw_bit;
  logic             rd;
  logic [7:0]       rnd_byte;
  logic             valid;
  logic             busy;
  logic             health_fail;
  logic [2:0]       state;

  modport master (
    output en, start, cfg_div, raw_bit, rd,
    input  rnd_byte, valid, busy, health_fail, state
  );

  modport slave (
    input  en, start, cfg_div, raw_bit, rd,
    output rnd_byte, valid, busy, health_fail, state
  );
endinterface

// File: rtl/trng_sample_ctrl.sv
// TRNG sampling controller: warm-up, programmable-rate sampling, Von Neumann
// debiasing into 8-bit words, and a continuous repetition-count health test.
module trng_sample_ctrl #(
  parameter int DIV_W     = 8,
  parameter int WARMUP    = 64,
  parameter int RCT_LIMIT = 32
) (
  input  logic                clk,
  input  logic                rst,
  trng_sample_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP_S = 3'd1,
    COLLECT = 3'd2,
    HOLD    = 3'd3,
    FAIL    = 3'd4
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       warm_cnt;
  logic [7:0]       rep_cnt;
  logic             prev_s;
  logic             pair_flag;
  logic             first_s;
  logic [3:0]       bit_cnt;
  logic [7:0]       sr;
  logic [7:0]       rnd_byte;
  logic             valid;
  logic             busy;
  logic             health_fail;

  logic             tick;
  logic             s;
  logic [7:0]       rep_next;
  logic             trip;
  logic [7:0]       sr_next;

  // rep_cnt of zero marks "no sample yet since start", so the first tick always restarts the run at 1
  always_comb begin
    tick     = (div_cnt == '0);
    s        = bus.raw_bit;
    rep_next = ((rep_cnt != 8'd0) && (s == prev_s)) ? rep_cnt + 8'd1 : 8'd1;
    trip     = tick && (rep_next == 8'(RCT_LIMIT));
    // A completed 10 pair yields 1 and 01 yields 0, so the output bit equals the first sample
    sr_next  = {sr[6:0], first_s};
  end

  // Main sequencer: tick divider, health test, pair conditioning and output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      div_cnt     <= '0;
      warm_cnt    <= 8'd0;
      rep_cnt     <= 8'd0;
      prev_s      <= 1'b0;
      pair_flag   <= 1'b0;
      first_s     <= 1'b0;
      bit_cnt     <= 4'd0;
      sr          <= 8'd0;
      rnd_byte    <= 8'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FAIL: begin
          if (bus.start && bus.en) begin
            div_q       <= bus.cfg_div;
            div_cnt     <= '0;
            warm_cnt    <= 8'd0;
            rep_cnt     <= 8'd0;
            prev_s      <= 1'b0;
            pair_flag   <= 1'b0;
            first_s     <= 1'b0;
            bit_cnt     <= 4'd0;
            sr          <= 8'd0;
            health_fail <= 1'b0;
            busy        <= 1'b1;
            state_q     <= WARMUP_S;
          end
        end
        WARMUP_S, COLLECT, HOLD: begin
          div_cnt <= tick ? div_q : div_cnt - DIV_W'(1);
          if (tick) begin
            rep_cnt <= rep_next;
            prev_s  <= s;
          end
          if (trip) begin
            state_q     <= FAIL;
            health_fail <= 1'b1;
            valid       <= 1'b0;
            rnd_byte    <= 8'd0;
            busy        <= 1'b0;
          end else if (!bus.en) begin
            state_q   <= IDLE;
            valid     <= 1'b0;
            busy      <= 1'b0;
            pair_flag <= 1'b0;
            bit_cnt   <= 4'd0;
            sr        <= 8'd0;
          end else begin
            case (state_q)
              WARMUP_S: begin
                if (tick) begin
                  if (warm_cnt == 8'(WARMUP - 1)) begin
                    warm_cnt  <= 8'd0;
                    pair_flag <= 1'b0;
                    bit_cnt   <= 4'd0;
                    state_q   <= COLLECT;
                  end else begin
                    warm_cnt <= warm_cnt + 8'd1;
                  end
                end
              end
              COLLECT: begin
                if (tick) begin
                  if (!pair_flag) begin
                    first_s   <= s;
                    pair_flag <= 1'b1;
                  end else begin
                    pair_flag <= 1'b0;
                    if (first_s != s) begin
                      sr      <= sr_next;
                      bit_cnt <= bit_cnt + 4'd1;
                      if (bit_cnt == 4'd7) begin
                        rnd_byte <= sr_next;
                        valid    <= 1'b1;
                        state_q  <= HOLD;
                      end
                    end
                  end
                end
              end
              HOLD: begin
                if (bus.rd && valid) begin
                  valid     <= 1'b0;
                  bit_cnt   <= 4'd0;
                  pair_flag <= 1'b0;
                  state_q   <= COLLECT;
                end
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rnd_byte    = rnd_byte;
  assign bus.valid       = valid;
  assign bus.busy        = busy;
  assign bus.health_fail = health_fail;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed self-checking bench for trng_sample_ctrl (WARMUP=4, RCT_LIMIT=32).
module tb_trng_sample_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   cur_div;

  trng_sample_ctrl_if #(.DIV_W(8)) bus ();

  trng_sample_ctrl #(
    .DIV_W(8),
    .WARMUP(4),
    .RCT_LIMIT(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Starts a run with the given divider; called at a falling edge, returns at the next one
  task automatic do_start(input int div);
    bus.cfg_div = 8'(div);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    cur_div     = div;
  endtask

  // Presents one sample for a full tick window; the tick falls on the window's first edge,
  // so the rest of the window carries the inverted bit to catch mistimed sampling
  task automatic send_bit(input logic b);
    bus.raw_bit = b;
    @(negedge clk);
    bus.raw_bit = ~b;
    repeat (cur_div) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(v[i]);
  endtask

  task automatic do_warmup();
    send_bits(32'h5, 3, 0);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.state, bus.rnd_byte, bus.valid, bus.busy, bus.health_fail} !== 13'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got state=%0d byte=%h valid=%b busy=%b hf=%b required all 0",
               bus.state, bus.rnd_byte, bus.valid, bus.busy, bus.health_fail);
    end
  endtask

  task automatic test_conditioning();
    bus.en = 1'b1;
    do_start(0);
    checks++;
    if (bus.state !== 3'd1 || bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL start_warmup: got state=%0d busy=%b required 1/1", bus.state, bus.busy);
    end
    do_warmup();
    checks++;
    if (bus.state !== 3'd2) begin
      fails++;
      $display("[TB] FAIL warmup_done: got state=%0d required 2", bus.state);
    end
    send_bits(32'h9A59, 15, 1);
    checks++;
    if (bus.valid !== 1'b0 || bus.state !== 3'd2) begin
      fails++;
      $display("[TB] FAIL seven_bits: got valid=%b state=%0d required 0/2", bus.valid, bus.state);
    end
    send_bits(32'h9A59, 0, 0);
    checks++;
    if (bus.rnd_byte !== 8'hB2 || bus.valid !== 1'b1 || bus.state !== 3'd3) begin
      fails++;
      $display("[TB] FAIL word_b2: got byte=%h valid=%b state=%0d required b2/1/3",
               bus.rnd_byte, bus.valid, bus.state);
    end
  endtask

  task automatic test_handshake();
    for (int i = 0; i < 20; i++) begin
      bus.raw_bit = i[0];
      @(negedge clk);
      checks++;
      if (bus.rnd_byte !== 8'hB2 || bus.valid !== 1'b1 || bus.state !== 3'd3) begin
        fails++;
        $display("[TB] FAIL hold_stable cycle %0d: got byte=%h valid=%b state=%0d required b2/1/3",
                 i, bus.rnd_byte, bus.valid, bus.state);
      end
    end
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.state !== 3'd2) begin
      fails++;
      $display("[TB] FAIL rd_ack: got valid=%b state=%0d required 0/2", bus.valid, bus.state);
    end
    send_bits(32'h65A6, 15, 0);
    checks++;
    if (bus.rnd_byte !== 8'h4D || bus.valid !== 1'b1 || bus.state !== 3'd3) begin
      fails++;
      $display("[TB] FAIL word_4d: got byte=%h valid=%b state=%0d required 4d/1/3",
               bus.rnd_byte, bus.valid, bus.state);
    end
  endtask

  task automatic test_reset_mid();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    send_bits(32'h26, 5, 0);
    checks++;
    if (bus.state !== 3'd2 || bus.valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_collect: got state=%0d valid=%b required 2/0", bus.state, bus.valid);
    end
    #2 rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL after_reset_idle: got state=%0d busy=%b required 0/0", bus.state, bus.busy);
    end
  endtask

  task automatic test_discard_divider();
    do_start(3);
    do_warmup();
    send_bits(32'h2D2E1D2D, 31, 1);
    checks++;
    if (bus.valid !== 1'b0 || bus.state !== 3'd2) begin
      fails++;
      $display("[TB] FAIL discard_pending: got valid=%b state=%0d required 0/2", bus.valid, bus.state);
    end
    bus.raw_bit = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rnd_byte !== 8'hB2 || bus.valid !== 1'b1 || bus.state !== 3'd3) begin
      fails++;
      $display("[TB] FAIL discard_word: got byte=%h valid=%b state=%0d required b2/1/3",
               bus.rnd_byte, bus.valid, bus.state);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable();
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL en_low_hold: got state=%0d valid=%b busy=%b required 0/0/0",
               bus.state, bus.valid, bus.busy);
    end
    bus.en = 1'b1;
  endtask

  task automatic test_start_ignored();
    do_start(0);
    do_warmup();
    send_bits(32'h9A59, 15, 10);
    bus.start = 1'b1;
    send_bit(1'b1);
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd2) begin
      fails++;
      $display("[TB] FAIL start_in_collect: got state=%0d required 2", bus.state);
    end
    send_bits(32'h9A59, 8, 0);
    checks++;
    if (bus.rnd_byte !== 8'hB2 || bus.valid !== 1'b1 || bus.state !== 3'd3) begin
      fails++;
      $display("[TB] FAIL start_ignored_word: got byte=%h valid=%b state=%0d required b2/1/3",
               bus.rnd_byte, bus.valid, bus.state);
    end
  endtask

  task automatic test_health();
    bus.en = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    do_start(0);
    bus.raw_bit = 1'b1;
    repeat (31) @(negedge clk);
    checks++;
    if (bus.health_fail !== 1'b0 || bus.state === 3'd4) begin
      fails++;
      $display("[TB] FAIL run31_no_trip: got hf=%b state=%0d required 0/not 4", bus.health_fail, bus.state);
    end
    bus.raw_bit = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.health_fail !== 1'b0) begin
      fails++;
      $display("[TB] FAIL run_broken: got hf=%b required 0", bus.health_fail);
    end
    bus.raw_bit = 1'b1;
    repeat (31) @(negedge clk);
    checks++;
    if (bus.health_fail !== 1'b0 || bus.state === 3'd4) begin
      fails++;
      $display("[TB] FAIL second_run31: got hf=%b state=%0d required 0/not 4", bus.health_fail, bus.state);
    end
    @(negedge clk);
    checks++;
    if (bus.health_fail !== 1'b1 || bus.state !== 3'd4 || bus.valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.rnd_byte !== 8'h00) begin
      fails++;
      $display("[TB] FAIL run32_trip: got hf=%b state=%0d valid=%b busy=%b byte=%h required 1/4/0/0/00",
               bus.health_fail, bus.state, bus.valid, bus.busy, bus.rnd_byte);
    end
    bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd4 || bus.health_fail !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fail_ignores_en: got state=%0d hf=%b required 4/1", bus.state, bus.health_fail);
    end
    bus.en = 1'b1;
    do_start(0);
    checks++;
    if (bus.state !== 3'd1 || bus.health_fail !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fail_cleared: got state=%0d hf=%b busy=%b required 1/0/1",
               bus.state, bus.health_fail, bus.busy);
    end
  endtask

  // Test sequence: each task leaves the DUT at a falling edge for the next
  initial begin
    checks      = 0;
    fails       = 0;
    cur_div     = 0;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    bus.cfg_div = 8'd0;
    bus.raw_bit = 1'b0;
    bus.rd      = 1'b0;
    #2 rst = 1'b1;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_conditioning();
    test_handshake();
    test_reset_mid();
    test_discard_divider();
    test_enable();
    test_start_ignored();
    test_health();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
